// File: rtl/vga_sync_decoder_if.sv
// Sync input and recovered timing bundle for vga_sync_decoder.
// master drives the sync stream, slave is the decoder.
interface vga_sync_decoder_if;
   logic        px_en;
   logic        hsync_in;
   logic        vsync_in;
   logic [10:0] x;
   logic [10:0] y;
   logic [10:0] line_len;
   logic [10:0] frame_lines;
   logic        locked;
   logic        h_err;
   logic        v_err;

   modport master (
      output px_en, hsync_in, vsync_in,
      input  x, y, line_len, frame_lines, locked, h_err, v_err
   );

   modport slave (
      input  px_en, hsync_in, vsync_in,
      output x, y, line_len, frame_lines, locked, h_err, v_err
   );
endinterface

// File: rtl/vga_sync_decoder.sv
// Measures incoming VGA sync timing, recovers x/y coordinates
// and declares lock after a run of frames matching the expected mode.
module vga_sync_decoder #(
   parameter int PX_COUNT    = 800,
   parameter int LINE_COUNT  = 525,
   parameter int H_SYNC_X    = 704,
   parameter int V_SYNC_Y    = 523,
   parameter int LOCK_FRAMES = 2
) (
   input logic clk,
   input logic reset,
   vga_sync_decoder_if.slave bus
);
   localparam logic [11:0] PX_L    = 12'(PX_COUNT);
   localparam logic [10:0] PX_LAST = 11'(PX_COUNT - 1);
   localparam logic [10:0] LN      = 11'(LINE_COUNT);
   localparam logic [10:0] LN_LAST = 11'(LINE_COUNT - 1);
   localparam logic [10:0] HX      = 11'(H_SYNC_X);
   localparam logic [10:0] VY      = 11'(V_SYNC_Y);
   localparam logic [3:0]  LF      = 4'(LOCK_FRAMES);
   localparam logic [10:0] SAT     = 11'h7ff;

   typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

   state_t      state;
   logic        hs_d, vs_d, h_valid, v_valid, h_bad;
   logic [10:0] h_cnt, v_cnt;
   logic [3:0]  good_cnt;
   logic [10:0] x_q, y_q, len_q, fl_q;
   logic        lock_q, herr_q, verr_q;

   logic        hfall, vfall, h_cap, v_cap, h_to, v_to;
   logic        herr_n, verr_n, frame_ok, x_wrap;
   logic [11:0] h_len;
   logic [10:0] v_eff;
   logic [3:0]  good_inc;

   assign hfall    = bus.px_en & hs_d & ~bus.hsync_in;
   assign vfall    = bus.px_en & vs_d & ~bus.vsync_in;
   assign h_len    = {1'b0, h_cnt} + 12'd1;
   assign h_cap    = hfall & h_valid;
   assign v_cap    = vfall & v_valid;
   assign h_to     = bus.px_en & ~hfall & (h_cnt == SAT - 11'd1);
   assign v_to     = hfall & ~vfall & (v_cnt == SAT - 11'd1);
   // an H-fall coinciding with the V-fall belongs to the ending frame
   assign v_eff    = (hfall && v_cnt != SAT) ? v_cnt + 11'd1 : v_cnt;
   assign herr_n   = (h_cap & (h_len != PX_L)) | h_to;
   assign verr_n   = (v_cap & (v_eff != LN)) | v_to;
   assign frame_ok = (v_eff == LN) & ~h_bad & ~herr_n;
   assign good_inc = good_cnt + 4'd1;
   assign x_wrap   = (x_q == PX_LAST);

   assign bus.x           = x_q;
   assign bus.y           = y_q;
   assign bus.line_len    = len_q;
   assign bus.frame_lines = fl_q;
   assign bus.locked      = lock_q;
   assign bus.h_err       = herr_q;
   assign bus.v_err       = verr_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= SEARCH;
         hs_d     <= 1'b1;
         vs_d     <= 1'b1;
         h_valid  <= 1'b0;
         v_valid  <= 1'b0;
         h_bad    <= 1'b0;
         h_cnt    <= '0;
         v_cnt    <= '0;
         good_cnt <= '0;
         x_q      <= '0;
         y_q      <= '0;
         len_q    <= '0;
         fl_q     <= '0;
         lock_q   <= 1'b0;
         herr_q   <= 1'b0;
         verr_q   <= 1'b0;
      end else begin
         herr_q <= 1'b0;
         verr_q <= 1'b0;
         if (bus.px_en) begin
            hs_d   <= bus.hsync_in;
            vs_d   <= bus.vsync_in;
            herr_q <= herr_n;
            verr_q <= verr_n;

            if (hfall) begin
               h_cnt <= '0;
               if (h_valid) len_q <= h_len[10:0];
               else         h_valid <= 1'b1;
            end else if (h_cnt != SAT) begin
               h_cnt <= h_cnt + 11'd1;
            end
            if (h_to) h_valid <= 1'b0;

            if (vfall) begin
               v_cnt <= '0;
               if (v_valid) fl_q <= v_eff;
               else         v_valid <= 1'b1;
            end else begin
               v_cnt <= v_eff;
            end
            if (v_to) v_valid <= 1'b0;

            if (hfall)       x_q <= HX;
            else if (x_wrap) x_q <= '0;
            else             x_q <= x_q + 11'd1;

            if (vfall)
               y_q <= VY;
            else if (x_wrap && !hfall)
               y_q <= (y_q == LN_LAST) ? '0 : y_q + 11'd1;

            if (vfall)       h_bad <= 1'b0;
            else if (herr_n) h_bad <= 1'b1;

            unique case (state)
               SEARCH: begin
                  if (vfall) begin
                     state    <= TRACK;
                     good_cnt <= '0;
                  end
               end
               TRACK: begin
                  if (h_to || v_to) begin
                     state    <= SEARCH;
                     good_cnt <= '0;
                  end else if (v_cap) begin
                     if (frame_ok) begin
                        good_cnt <= good_inc;
                        if (good_inc == LF) begin
                           state  <= LOCKED;
                           lock_q <= 1'b1;
                        end
                     end else begin
                        good_cnt <= '0;
                     end
                  end
               end
               LOCKED: begin
                  if (herr_n || verr_n) begin
                     state    <= SEARCH;
                     good_cnt <= '0;
                     lock_q   <= 1'b0;
                  end
               end
               default: state <= SEARCH;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder: frame table drives a sync generator,
// expectations are queued per sync event and compared one clk later.
module tb_vga_sync_decoder;
   localparam int PXC = 20;
   localparam int LC  = 12;
   localparam int HSX = 16;
   localparam int VSY = 10;
   localparam int LF  = 2;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   vga_sync_decoder_if bus();

   vga_sync_decoder #(
      .PX_COUNT(PXC), .LINE_COUNT(LC), .H_SYNC_X(HSX),
      .V_SYNC_Y(VSY), .LOCK_FRAMES(LF)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   typedef struct {
      int nlines; int l3_len; int rst_line;
      int fl; bit verr; bit lk;
   } frame_t;

   typedef struct {
      int due; string nm;
      bit chk_ll; int ll; bit herr; bit verr;
      bit chk_fl; int fl; bit chk_lk; bit lk;
      bit chk_x; int xv; bit chk_y; int yv;
   } exp_t;

   exp_t   sb[$];
   frame_t ft[15];
   frame_t cur_f;
   int cyc = 0;
   int n_chk = 0;
   int n_fail = 0;
   bit prev_hs = 1'b1, prev_vs = 1'b1, hv = 1'b0;
   int since_hf = 0, hf_len = 0, cur_ll = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cyc %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   function automatic exp_t mk(input string nm);
      exp_t r;
      r.nm  = nm;
      r.due = cyc + 1;
      return r;
   endfunction

   exp_t e_mon;
   always @(negedge clk) begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
         e_mon = sb.pop_front();
         chk({e_mon.nm, ".h_err"}, bus.h_err, e_mon.herr);
         chk({e_mon.nm, ".v_err"}, bus.v_err, e_mon.verr);
         if (e_mon.chk_ll) chk({e_mon.nm, ".line_len"}, bus.line_len, e_mon.ll);
         if (e_mon.chk_fl) chk({e_mon.nm, ".frame_lines"}, bus.frame_lines, e_mon.fl);
         if (e_mon.chk_lk) chk({e_mon.nm, ".locked"}, bus.locked, e_mon.lk);
         if (e_mon.chk_x)  chk({e_mon.nm, ".x"}, bus.x, e_mon.xv);
         if (e_mon.chk_y)  chk({e_mon.nm, ".y"}, bus.y, e_mon.yv);
      end else if (!reset) begin
         chk("idle_err_pulse", {bus.h_err, bus.v_err}, 0);
      end
   end

   task automatic chk_rst(input string nm);
      chk({nm, ".x"}, bus.x, 0);
      chk({nm, ".y"}, bus.y, 0);
      chk({nm, ".line_len"}, bus.line_len, 0);
      chk({nm, ".frame_lines"}, bus.frame_lines, 0);
      chk({nm, ".locked"}, bus.locked, 0);
      chk({nm, ".h_err"}, bus.h_err, 0);
      chk({nm, ".v_err"}, bus.v_err, 0);
   endtask

   task automatic pix(input bit hs, input bit vs, input int len,
                      input bit wchk);
      bit hf, vf;
      exp_t e;
      hf = prev_hs & !hs;
      vf = prev_vs & !vs;
      prev_hs = hs;
      prev_vs = vs;
      bus.hsync_in = hs;
      bus.vsync_in = vs;
      bus.px_en = 1'b1;
      if (hf) begin
         e = mk("hfall");
         e.chk_x = 1'b1;
         e.xv = HSX;
         e.chk_ll = 1'b1;
         if (hv) begin
            cur_ll = hf_len;
            e.herr = (hf_len != PXC);
            e.chk_lk = e.herr;
         end else begin
            hv = 1'b1;
         end
         e.ll = cur_ll;
         hf_len = len;
         since_hf = 0;
         sb.push_back(e);
      end else begin
         since_hf++;
         if (since_hf == 2047) begin
            e = mk("h_timeout");
            e.herr = 1'b1;
            e.chk_lk = 1'b1;
            hv = 1'b0;
            sb.push_back(e);
         end
      end
      if (vf) begin
         e = mk("vfall");
         e.chk_fl = 1'b1;
         e.fl = cur_f.fl;
         e.verr = cur_f.verr;
         e.chk_lk = 1'b1;
         e.lk = cur_f.lk;
         e.chk_y = 1'b1;
         e.yv = VSY;
         sb.push_back(e);
      end
      if (wchk) begin
         e = mk("x_wrap");
         e.chk_x = 1'b1;
         e.xv = 0;
         e.chk_y = 1'b1;
         e.yv = VSY + 1;
         sb.push_back(e);
      end
      @(posedge clk); #1;
      // sync glitches between pixel enables must be ignored
      bus.px_en = 1'b0;
      bus.hsync_in = 1'b0;
      bus.vsync_in = 1'b0;
      @(posedge clk); #1;
      bus.hsync_in = hs;
      bus.vsync_in = vs;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      bus.px_en = 1'b0;
      bus.hsync_in = 1'b1;
      bus.vsync_in = 1'b1;
      reset = 1'b1;
      @(posedge clk); #1;
      chk_rst("mid_reset");
      chk("mid_reset.sb_empty", sb.size(), 0);
      reset = 1'b0;
      prev_hs = 1'b1;
      prev_vs = 1'b1;
      hv = 1'b0;
      since_hf = 0;
      cur_ll = 0;
   endtask

   task automatic run_frame(input frame_t f);
      cur_f = f;
      for (int l = 0; l < f.nlines; l++) begin
         int len;
         len = (l == 3) ? f.l3_len : PXC;
         for (int p = 0; p < len; p++) begin
            if (l == f.rst_line && p == 5) begin
               do_reset();
               return;
            end
            pix(!(p >= 12 && p < 15), l >= 2, len, (l == 0 && p == 16));
         end
      end
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // nlines, line3 length, reset line, then the checks made
      // at this frame's V-fall about the frame before it
      ft[0]  = '{LC,     PXC,     -1,  0, 1'b0, 1'b0};
      ft[1]  = '{LC,     PXC,     -1, LC, 1'b0, 1'b0};
      ft[2]  = '{LC,     PXC,     -1, LC, 1'b0, 1'b1};
      ft[3]  = '{LC,     PXC + 1, -1, LC, 1'b0, 1'b1};
      ft[4]  = '{LC,     PXC,     -1, LC, 1'b0, 1'b0};
      ft[5]  = '{LC,     PXC,     -1, LC, 1'b0, 1'b0};
      ft[6]  = '{LC,     PXC,     -1, LC, 1'b0, 1'b1};
      ft[7]  = '{LC,     PXC,     -1, LC, 1'b0, 1'b0};
      ft[8]  = '{LC - 1, PXC,     -1, LC, 1'b0, 1'b0};
      ft[9]  = '{LC,     PXC,     -1, LC - 1, 1'b1, 1'b0};
      ft[10] = '{LC,     PXC,     -1, LC, 1'b0, 1'b0};
      ft[11] = '{LC,     PXC,      5, LC, 1'b0, 1'b1};
      ft[12] = '{LC,     PXC,     -1,  0, 1'b0, 1'b0};
      ft[13] = '{LC,     PXC,     -1, LC, 1'b0, 1'b0};
      ft[14] = '{LC,     PXC,     -1, LC, 1'b0, 1'b1};

      bus.px_en = 1'b0;
      bus.hsync_in = 1'b1;
      bus.vsync_in = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk_rst("por");
      reset = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 15; i++) begin
         run_frame(ft[i]);
         if (i == 6)
            repeat (2100) pix(1'b1, 1'b1, PXC, 1'b0);
      end

      repeat (8) @(posedge clk);
      #1;
      chk("sb_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/vga_sync_decoder.md
# vga_sync_decoder

Receive-side counterpart to the VGA pixel/line timing generator. It samples incoming hsync/vsync on the pixel enable, measures line length in pixels and frame height in lines, and recovers x/y pixel coordinates. It declares lock once the measured timing matches the expected mode for a programmable number of consecutive frames. It sits behind a sync source in the same clock domain, such as the generator in loopback or a capture front end, and feeds downstream logic that needs coordinates.

## Interface
Parameters:
- PX_COUNT, 800: expected pixels per line (px_en samples between hsync falling edges).
- LINE_COUNT, 525: expected lines per frame (hsync falls between vsync falling edges).
- H_SYNC_X, 704: x value assigned at the hsync falling edge.
- V_SYNC_Y, 523: y value assigned at the vsync falling edge.
- LOCK_FRAMES, 2: consecutive good frames required to lock (1..15).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- px_en  in  1  pixel enable, one cycle per pixel (1-in-4 clk in the standard build).
- hsync_in  in  1  horizontal sync, active-low pulse, synchronous to clk.
- vsync_in  in  1  vertical sync, active-low pulse, synchronous to clk.
- x  out  11  recovered pixel coordinate.
- y  out  11  recovered line coordinate.
- line_len  out  11  last measured line period in pixels.
- frame_lines  out  11  last measured frame period in lines.
- locked  out  1  timing matches expected mode.
- h_err  out  1  one-clk pulse: bad line period or hsync timeout.
- v_err  out  1  one-clk pulse: bad frame period or vsync timeout.

## Operation
- All state advances only on clk edges where px_en=1. The only exceptions are reset, and h_err/v_err deassertion, which happens after exactly one clk.
- Edge detect:
  - hs_d and vs_d hold the previous px_en sample of hsync_in and vsync_in. Both reset to 1.
  - H-fall occurs when px_en=1, hs_d=1 and hsync_in=0. V-fall is defined the same way.
- Line measurement:
  - h_cnt increments per px_en and saturates at 2047.
  - On H-fall: line_len<=h_cnt+1 (captures period), then h_cnt<=0.
  - The first H-fall after reset or timeout does not capture (h_valid<=1 instead).
- Frame measurement:
  - v_cnt increments per H-fall and saturates at 2047.
  - On V-fall: frame_lines<=v_cnt, then v_cnt<=0. If H-fall and V-fall occur together, the H-fall is counted first.
  - The first V-fall after reset does not capture.
- Coordinates:
  - x increments per px_en and wraps from PX_COUNT-1 to 0.
  - On H-fall, x<=H_SYNC_X, overriding the increment.
  - y increments on each x wrap and wraps from LINE_COUNT-1 to 0.
  - On V-fall, y<=V_SYNC_Y, overriding. Coordinates free-run when unlocked.
- Errors:
  - h_err pulses on a capturing H-fall with h_cnt+1≠PX_COUNT. It also pulses once when h_cnt reaches 2047; h_valid is then cleared.
  - v_err pulses on a capturing V-fall with v_cnt≠LINE_COUNT. It also pulses once when v_cnt reaches 2047.
- Lock state machine, with good_cnt as a 4-bit counter:
  - SEARCH: locked=0. The first V-fall moves to TRACK with good_cnt=0.
  - TRACK: at each capturing V-fall, if the frame is good (v_cnt=LINE_COUNT and no h_err since the previous V-fall), good_cnt++. Otherwise good_cnt<=0.
    - When the incremented good_cnt equals LOCK_FRAMES, go to LOCKED.
    - A timeout goes to SEARCH.
  - LOCKED: locked=1. Any h_err or v_err returns to SEARCH the same edge, with locked=0 on the next cycle and good_cnt=0.
- Reset mid-operation has the same effect as power-up reset. Any frame in progress is discarded.

## Timing
- Reset values:
  - x=0, y=0, line_len=0, frame_lines=0.
  - locked=0, h_err=0, v_err=0.
  - State is SEARCH; h_cnt, v_cnt and good_cnt are 0; h_valid=0.
- All outputs are registered. Latency from the px_en edge sampling the falling sync to updated line_len, frame_lines, x, y or error output is 1 clk.
- locked rises 1 clk after the V-fall that completes the LOCK_FRAMES-th good frame.
- locked falls 1 clk after the offending error sample.
- h_err and v_err are never wider than 1 clk. They can both assert in the same cycle.
- Sync edges while px_en=0 are ignored until the next px_en sample.

## Test plan
- Loopback from the generator with default timing, 3 frames:
  - line_len=800 after the second hsync.
  - frame_lines=525 after the second vsync.
  - locked=1 after the V-fall ending frame 3 (first capture plus 2 good frames).
  - No h_err or v_err.
- Locked stream, then one line stretched to 801 pixels:
  - h_err pulses 1 clk with line_len=801.
  - locked=0 next clk.
  - Relock after 2 further good frames.
- hsync held high for 2100 px_en: exactly one h_err when h_cnt hits 2047; locked=0; the next H-fall does not capture.
- Frame with 524 lines while in TRACK (good_cnt=1): v_err pulses, frame_lines=524, good_cnt returns to 0, locked stays 0.
- Coordinate check: at the clk after H-fall, x=704; at the clk after V-fall, y=523; x wraps 799→0 and y increments together.
- Assert reset mid-frame while locked:
  - All outputs return to reset values on the next clk.
  - The next lock takes the full count of frames again.
